// File: rtl/dmem_arbiter_if.sv
// Bundle of the processor, auxiliary and dmem-side signals of dmem_arbiter.
// slave = arbiter view, master = requesters plus memory view.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic              proc_req;
  logic              proc_wren;
  logic [ADDR_W-1:0] proc_addr;
  logic [DATA_W-1:0] proc_data;
  logic              proc_gnt;
  logic              proc_rvalid;
  logic [DATA_W-1:0] proc_q;

  logic              aux_req;
  logic              aux_wren;
  logic [ADDR_W-1:0] aux_addr;
  logic [DATA_W-1:0] aux_data;
  logic              aux_gnt;
  logic              aux_rvalid;
  logic [DATA_W-1:0] aux_q;

  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data;
  logic              mem_wren;
  logic [DATA_W-1:0] mem_q;

  modport slave (
    input  proc_req, proc_wren, proc_addr, proc_data,
    output proc_gnt, proc_rvalid, proc_q,
    input  aux_req, aux_wren, aux_addr, aux_data,
    output aux_gnt, aux_rvalid, aux_q,
    output mem_address, mem_data, mem_wren,
    input  mem_q
  );

  modport master (
    output proc_req, proc_wren, proc_addr, proc_data,
    input  proc_gnt, proc_rvalid, proc_q,
    output aux_req, aux_wren, aux_addr, aux_data,
    input  aux_gnt, aux_rvalid, aux_q,
    input  mem_address, mem_data, mem_wren,
    output mem_q
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares the single-port dmem between processor and auxiliary requesters.
// Round-robin by default; define DMEM_ARB_FIXED_PRIO_EN for processor priority.
module dmem_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic           clock,
  input  logic           reset,
  dmem_arbiter_if.slave  bus,
  output logic [15:0]    conflict_cnt
);

  typedef enum logic {
    LAST_PROC = 1'b0,
    LAST_AUX  = 1'b1
  } last_gnt_e;

  last_gnt_e         last_gnt_q, last_gnt_d;
  logic [1:0]        rd_pend_q, rd_pend_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              gnt_proc, gnt_aux, both_req;
  logic [ADDR_W-1:0] addr_mux;
  logic [DATA_W-1:0] data_mux;
  logic              wren_mux;

  always_ff @(posedge clock) begin
    if (reset) begin
      last_gnt_q <= LAST_AUX;
      rd_pend_q  <= '0;
      cnt_q      <= '0;
    end else begin
      last_gnt_q <= last_gnt_d;
      rd_pend_q  <= rd_pend_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    both_req = bus.proc_req & bus.aux_req;
`ifdef DMEM_ARB_FIXED_PRIO_EN
    gnt_proc = bus.proc_req;
`else
    gnt_proc = bus.proc_req & (~bus.aux_req | (last_gnt_q == LAST_AUX));
`endif
    gnt_aux  = bus.aux_req & ~gnt_proc;

    last_gnt_d = last_gnt_q;
    if (gnt_proc) begin
      last_gnt_d = LAST_PROC;
    end else if (gnt_aux) begin
      last_gnt_d = LAST_AUX;
    end

    rd_pend_d = {gnt_aux & ~bus.aux_wren, gnt_proc & ~bus.proc_wren};

    cnt_d = cnt_q;
    if (both_req && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end

    addr_mux = '0;
    data_mux = '0;
    wren_mux = 1'b0;
    if (gnt_proc) begin
      addr_mux = bus.proc_addr;
      data_mux = bus.proc_data;
      wren_mux = bus.proc_wren;
    end else if (gnt_aux) begin
      addr_mux = bus.aux_addr;
      data_mux = bus.aux_data;
      wren_mux = bus.aux_wren;
    end
  end

  always_comb begin
    bus.proc_gnt    = gnt_proc;
    bus.aux_gnt     = gnt_aux;
    bus.mem_address = addr_mux;
    bus.mem_data    = data_mux;
    bus.mem_wren    = wren_mux;
    // Reset masks a read still in flight so its data is never reported.
    bus.proc_rvalid = rd_pend_q[0] & ~reset;
    bus.aux_rvalid  = rd_pend_q[1] & ~reset;
    bus.proc_q      = bus.mem_q;
    bus.aux_q       = bus.mem_q;
    conflict_cnt    = cnt_q;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a behavioural dmem and read scoreboard.
module tb_dmem_arbiter;

`ifdef DMEM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  typedef struct {
    bit          port;   // 0 = proc, 1 = aux
    logic [31:0] data;
    int          due;
  } sb_t;

  logic        clock;
  logic        reset;
  logic [15:0] conflict_cnt;

  dmem_arbiter_if #(.ADDR_W(12), .DATA_W(32)) bus ();

  dmem_arbiter #(.ADDR_W(12), .DATA_W(32)) dut (
    .clock        (clock),
    .reset        (reset),
    .bus          (bus),
    .conflict_cnt (conflict_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Storage holds value ^ pat(addr) so an unwritten word reads back as pat(addr).
  bit [31:0] mem_arr [0:4095];
  bit [31:0] shadow  [0:4095];

  function automatic logic [31:0] pat(input logic [11:0] a);
    return {4'hC, a, 4'h3, a};
  endfunction

  always @(posedge clock) begin
    bus.mem_q <= mem_arr[bus.mem_address] ^ pat(bus.mem_address);
    if (bus.mem_wren) mem_arr[bus.mem_address] <= bus.mem_data ^ pat(bus.mem_address);
  end

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc   = 0;
  bit          m_last;
  logic [15:0] m_cnt;
  sb_t         sb[$];

  task automatic idle_inputs();
    bus.proc_req = 1'b0; bus.proc_wren = 1'b0; bus.proc_addr = '0; bus.proc_data = '0;
    bus.aux_req  = 1'b0; bus.aux_wren  = 1'b0; bus.aux_addr  = '0; bus.aux_data  = '0;
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b1;
    idle_inputs();
    @(posedge clock); #1;
    reset  = 1'b0;
    m_last = 1'b1;
    m_cnt  = '0;
    sb.delete();
  endtask

  task automatic run_cycle(input bit preq, input bit pwr, input logic [11:0] paddr,
                           input logic [31:0] pdata, input bit areq, input bit awr,
                           input logic [11:0] aaddr, input logic [31:0] adata);
    bit          egp, ega, ewr, epv, eav;
    logic [11:0] ea;
    logic [31:0] ed;
    sb_t         e;
    @(posedge clock); #1;
    bus.proc_req = preq; bus.proc_wren = pwr; bus.proc_addr = paddr; bus.proc_data = pdata;
    bus.aux_req  = areq; bus.aux_wren  = awr; bus.aux_addr  = aaddr; bus.aux_data  = adata;
    cyc++;
    @(negedge clock);
    if (preq && areq) egp = FIXED ? 1'b1 : m_last;
    else              egp = preq;
    ega = areq && !egp;
    ea  = egp ? paddr : (ega ? aaddr : 12'h000);
    ed  = egp ? pdata : (ega ? adata : 32'h0);
    ewr = egp ? pwr   : (ega ? awr   : 1'b0);

    n_cmp++;
    if ({bus.proc_gnt, bus.aux_gnt} !== {egp, ega}) begin
      n_bad++;
      $display("FAIL gnt cyc=%0d got proc/aux=%b%b exp=%b%b", cyc, bus.proc_gnt, bus.aux_gnt, egp, ega);
    end
    n_cmp++;
    if ({bus.mem_wren, bus.mem_address, bus.mem_data} !== {ewr, ea, ed}) begin
      n_bad++;
      $display("FAIL mem_bus cyc=%0d got wr=%b a=%h d=%h exp wr=%b a=%h d=%h",
               cyc, bus.mem_wren, bus.mem_address, bus.mem_data, ewr, ea, ed);
    end

    while (sb.size() > 0 && sb[0].due < cyc) begin
      n_cmp++; n_bad++;
      $display("FAIL rvalid_missing cyc=%0d due=%0d", cyc, sb[0].due);
      void'(sb.pop_front());
    end
    epv = (sb.size() > 0) && (sb[0].due == cyc) && (sb[0].port == 1'b0);
    eav = (sb.size() > 0) && (sb[0].due == cyc) && (sb[0].port == 1'b1);
    n_cmp++;
    if ({bus.proc_rvalid, bus.aux_rvalid} !== {epv, eav}) begin
      n_bad++;
      $display("FAIL rvalid cyc=%0d got proc/aux=%b%b exp=%b%b", cyc, bus.proc_rvalid, bus.aux_rvalid, epv, eav);
    end
    if (epv || eav) begin
      e = sb.pop_front();
      n_cmp++;
      if ((e.port ? bus.aux_q : bus.proc_q) !== e.data) begin
        n_bad++;
        $display("FAIL rdata cyc=%0d port=%0d got=%h exp=%h", cyc, e.port,
                 e.port ? bus.aux_q : bus.proc_q, e.data);
      end
    end
    n_cmp++;
    if (conflict_cnt !== m_cnt) begin
      n_bad++;
      $display("FAIL conflict_cnt cyc=%0d got=%h exp=%h", cyc, conflict_cnt, m_cnt);
    end

    if (egp || ega) begin
      if (ewr) shadow[ea] = ed ^ pat(ea);
      else     sb.push_back('{port: ega, data: shadow[ea] ^ pat(ea), due: cyc + 1});
      m_last = ega;
    end
    if (preq && areq && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clock);
    n_cmp++;
    if ({bus.proc_rvalid, bus.aux_rvalid, bus.proc_gnt, bus.aux_gnt} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_flags got rv=%b%b gnt=%b%b exp 0000", bus.proc_rvalid, bus.aux_rvalid,
               bus.proc_gnt, bus.aux_gnt);
    end
    n_cmp++;
    if ({bus.mem_wren, bus.mem_address, bus.mem_data} !== 45'h0) begin
      n_bad++;
      $display("FAIL reset_mem got wr=%b a=%h d=%h exp zero", bus.mem_wren, bus.mem_address, bus.mem_data);
    end
    n_cmp++;
    if (conflict_cnt !== 16'h0000) begin
      n_bad++;
      $display("FAIL reset_cnt got=%h exp=0000", conflict_cnt);
    end
  endtask

  task automatic test_proc_read();
    run_cycle(1'b1, 1'b0, 12'h010, 32'h0, 1'b0, 1'b0, 12'h0, 32'h0);
    run_cycle(1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 12'h0, 32'h0);
  endtask

  task automatic test_aux_write_read();
    run_cycle(1'b0, 1'b0, 12'h0, 32'h0, 1'b1, 1'b1, 12'h020, 32'hDEADBEEF);
    run_cycle(1'b0, 1'b0, 12'h0, 32'h0, 1'b1, 1'b0, 12'h020, 32'h0);
    n_cmp++;
    if (!bus.aux_gnt || bus.mem_address !== 12'h020) begin
      n_bad++;
      $display("FAIL aux_read_issue got gnt=%b a=%h exp gnt=1 a=020", bus.aux_gnt, bus.mem_address);
    end
    run_cycle(1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 12'h0, 32'h0);
    n_cmp++;
    if (!bus.aux_rvalid || bus.aux_q !== 32'hDEADBEEF) begin
      n_bad++;
      $display("FAIL aux_readback got rv=%b q=%h exp rv=1 q=deadbeef", bus.aux_rvalid, bus.aux_q);
    end
  endtask

  task automatic test_conflict();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      run_cycle(1'b1, 1'b0, 12'(12'h100 + i), 32'h0, 1'b1, 1'b0, 12'(12'h200 + i), 32'h0);
      n_cmp++;
      if (bus.proc_gnt !== (FIXED ? 1'b1 : ((i % 2) == 0))) begin
        n_bad++;
        $display("FAIL conflict_seq i=%0d got proc_gnt=%b", i, bus.proc_gnt);
      end
    end
    run_cycle(1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 12'h0, 32'h0);
    n_cmp++;
    if (conflict_cnt !== 16'd6) begin
      n_bad++;
      $display("FAIL conflict_count got=%0d exp=6", conflict_cnt);
    end
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    run_cycle(1'b1, 1'b0, 12'h030, 32'h0, 1'b1, 1'b0, 12'h031, 32'h0);
    run_cycle(1'b1, 1'b0, 12'h030, 32'h0, 1'b1, 1'b0, 12'h031, 32'h0);
    run_cycle(1'b1, 1'b0, 12'h032, 32'h0, 1'b0, 1'b0, 12'h000, 32'h0);
    @(posedge clock); #1;
    reset = 1'b1;
    idle_inputs();
    @(negedge clock);
    n_cmp++;
    if ({bus.proc_rvalid, bus.aux_rvalid} !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_mid_read got rv=%b%b exp 00", bus.proc_rvalid, bus.aux_rvalid);
    end
    @(posedge clock); #1;
    reset  = 1'b0;
    m_last = 1'b1;
    m_cnt  = '0;
    sb.delete();
    @(negedge clock);
    n_cmp++;
    if ({bus.proc_rvalid, conflict_cnt} !== 17'h0) begin
      n_bad++;
      $display("FAIL post_reset got rv=%b cnt=%h exp 0/0000", bus.proc_rvalid, conflict_cnt);
    end
    run_cycle(1'b1, 1'b0, 12'h040, 32'h0, 1'b1, 1'b0, 12'h041, 32'h0);
    n_cmp++;
    if (bus.proc_gnt !== 1'b1) begin
      n_bad++;
      $display("FAIL post_reset_winner got proc_gnt=%b exp 1", bus.proc_gnt);
    end
    run_cycle(1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 12'h0, 32'h0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 60; i++) begin
      run_cycle(1'($urandom_range(1)), 1'($urandom_range(1)), 12'($urandom_range(15)), $urandom,
                1'($urandom_range(1)), 1'($urandom_range(1)), 12'($urandom_range(15)), $urandom);
    end
    run_cycle(1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 12'h0, 32'h0);
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 65540; i++) begin
      run_cycle(1'b1, 1'b0, 12'h050, 32'h0, 1'b1, 1'b0, 12'h051, 32'h0);
    end
    run_cycle(1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 12'h0, 32'h0);
    n_cmp++;
    if (conflict_cnt !== 16'hFFFF) begin
      n_bad++;
      $display("FAIL saturation got=%h exp=ffff", conflict_cnt);
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    m_last = 1'b1;
    m_cnt  = '0;
    test_reset();
    test_proc_read();
    test_aux_write_read();
    test_conflict();
    test_reset_mid_read();
    test_back_to_back();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
